limn2600_cache_ctrl: RTL and testbench
======================================

// Module: limn2600_cache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate cache controller between the Limn2600
//  load/store stage and the memory bus; sits directly upstream of main memory and owns the
//  tag/valid/data arrays. Read hits return data from the arrays; read misses fill a whole
//  line over a req/ack bus; writes always go to memory and update the line on a hit.
// PARAMETERS
//  LINES      16  number of cache lines (power of 2, >=2); INDEX_W = log2(LINES)
//  LINE_WORDS 4   32-bit words per line (power of 2, >=2); OFF_W = log2(LINE_WORDS)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous reset, active-low (rst==0 resets)
//  flush      in   1   invalidate all lines (accepted only in IDLE)
//  cpu_req    in   1   CPU access request, held until cpu_ready
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   32  byte address; bits [1:0] ignored
//  cpu_wdata  in   32  write data
//  cpu_rdata  out  32  read data, valid while cpu_ready=1 on a read
//  cpu_ready  out  1   one-cycle completion pulse
//  busy       out  1   1 whenever state != IDLE
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   memory write strobe, qualified by mem_req
//  mem_addr   out  32  word-aligned memory address ([1:0]=0)
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, sampled when mem_ack=1
//  mem_ack    in   1   memory completion, one cycle per transfer
// BEHAVIOUR
//  Address split: off=addr[OFF_W+1:2], idx=addr[OFF_W+INDEX_W+1:OFF_W+2], tag=remaining
//  high bits. hit = valid[idx] && tag_array[idx]==tag.
//  Reset (rst=0, async): state=IDLE, all valid bits 0, cpu_ready=0, cpu_rdata=0, mem_req=0,
//  mem_we=0, mem_addr=0, mem_wdata=0, busy=0, fill counter=0. Data/tag arrays are not reset.
//  FSM: IDLE -> LOOKUP -> {RESP | FILL | WRITE}; FILL -> RESP; WRITE -> RESP; RESP -> IDLE.
//  IDLE: if flush=1, clear all valid bits this cycle and stay IDLE (flush wins over a
//   simultaneous cpu_req; that request is taken the next cycle if still held). Else if cpu_req=1,
//   latch addr/we/wdata into internal regs and go LOOKUP.
//  LOOKUP: compare on latched address. Read hit -> RESP with cpu_rdata=data[idx][off].
//   Read miss -> FILL, counter=0. Write (hit or miss) -> WRITE.
//  FILL: mem_req=1, mem_we=0, mem_addr={tag,idx,counter,2'b00}. On mem_ack: store mem_rdata in
//   data[idx][counter]; if counter==LINE_WORDS-1 then set tag_array[idx]=tag, valid[idx]=1,
//   cpu_rdata=word at off (from the ack data if off is last word) and go RESP; else counter+1.
//   mem_req drops for exactly one cycle after each ack. Line is marked valid only after the
//   final word; an earlier abort leaves valid[idx]=0.
//  WRITE: mem_req=1, mem_we=1, mem_addr={latched addr[31:2],2'b00}, mem_wdata=latched wdata.
//   On mem_ack: if hit (evaluated in LOOKUP), data[idx][off]=wdata; miss leaves arrays
//   untouched. Go RESP.
//  RESP: cpu_ready=1 for exactly one cycle; cpu_rdata holds its value until next response;
//   on writes cpu_rdata is unchanged. Then IDLE. CPU must deassert or present a new request;
//   a held cpu_req in the cycle after RESP starts a new access.
//  Latency (cpu_req sampled at edge 0): read hit ready at edge 2 (visible cycle 2);
//   read miss 2 + sum of fill transfer cycles; write 2 + memory latency.
//  flush outside IDLE is ignored (not queued). mem_ack outside FILL/WRITE is ignored.
//  rst asserted mid-FILL/WRITE aborts immediately; mem_req drops asynchronously.
// TESTING
//  1 reset then read 0x0000_0100: mem sees 4 reads 0x100,0x104,0x108,0x10C; ack 1 cycle
//    later each with 0xA0..0xA3 -> cpu_rdata=0xA0, one cpu_ready pulse, valid[0]=1.
//  2 repeat read 0x0000_0108 -> no mem_req, cpu_ready 2 cycles after req, cpu_rdata=0xA2.
//  3 write 0xDEADBEEF to 0x104 (hit) -> mem write 0x104/0xDEADBEEF; re-read 0x104 hits with
//    0xDEADBEEF. Write to 0x1000 (miss) -> mem write, later read of 0x1000 misses and fills.
//  4 read 0x0000_0500 (same idx as 0x100, other tag) -> refill, 0x100 then misses again.
//  5 flush and cpu_req same cycle in IDLE -> all valid cleared, request served next cycle as
//    miss; flush pulsed during FILL -> ignored, fill completes, line valid.
//  6 rst low after 2nd fill ack -> mem_req=0 at once, busy=0; read to same line misses.

Source files
------------

// File: rtl/limn2600_cache_ctrl_if.sv
// CPU-side and memory-side handshake signals of the Limn2600 cache controller.
// master: the cache controller. slave: the CPU/memory environment around it.
interface limn2600_cache_ctrl_if;
   logic        flush;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      input  flush, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, busy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output flush, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, busy, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/limn2600_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller for Limn2600.
// Read misses fill a whole line word by word; writes always go to memory.
module limn2600_cache_ctrl #(
   parameter int unsigned LINES      = 16,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   limn2600_cache_ctrl_if.master bus
);
   localparam int unsigned INDEX_W = $clog2(LINES);
   localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
   localparam int unsigned TAG_W   = 32 - 2 - OFF_W - INDEX_W;
   localparam int unsigned DEPTH   = LINES * LINE_WORDS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_FILL,
      S_WRITE,
      S_RESP
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:2]        r_addr;
   logic [31:0]        r_wdata;
   logic               r_we;
   logic               r_hit;
   logic [OFF_W-1:0]   r_cnt;
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag_arr [LINES];
   logic [31:0]        r_data_arr [DEPTH];

   logic               r_cpu_ready;
   logic [31:0]        r_cpu_rdata;
   logic               r_busy;
   logic               r_mem_req;
   logic               r_mem_we;
   logic [31:0]        r_mem_addr;
   logic [31:0]        r_mem_wdata;

   logic [OFF_W-1:0]   w_off;
   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit;
   logic               w_unused;

   logic               w_flush;
   logic               w_latch;
   logic               w_fill_wr;
   logic               w_fill_done;
   logic               w_write_upd;
   logic [OFF_W-1:0]   w_cnt_nxt;
   logic               w_cpu_ready_nxt;
   logic [31:0]        w_cpu_rdata_nxt;
   logic               w_mem_req_nxt;
   logic               w_mem_we_nxt;
   logic [31:0]        w_mem_addr_nxt;
   logic [31:0]        w_mem_wdata_nxt;

   // Byte-lane bits of the CPU address carry no meaning for word accesses
   assign w_unused = ^bus.cpu_addr[1:0];

   // Address fields and hit test, always on the latched request address
   assign w_off = r_addr[OFF_W+1:2];
   assign w_idx = r_addr[OFF_W+INDEX_W+1:OFF_W+2];
   assign w_tag = r_addr[31:OFF_W+INDEX_W+2];
   assign w_hit = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);

   assign bus.cpu_ready = r_cpu_ready;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.busy      = r_busy;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_flush         = 1'b0;
      w_latch         = 1'b0;
      w_fill_wr       = 1'b0;
      w_fill_done     = 1'b0;
      w_write_upd     = 1'b0;
      w_cnt_nxt       = r_cnt;
      w_cpu_ready_nxt = 1'b0;
      w_cpu_rdata_nxt = r_cpu_rdata;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      case (r_state)
         S_IDLE: begin
            if (bus.flush) begin
               w_flush = 1'b1;
            end else if (bus.cpu_req) begin
               w_latch     = 1'b1;
               w_state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (r_we) begin
               w_state_nxt     = S_WRITE;
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = 1'b1;
               w_mem_addr_nxt  = {r_addr[31:2], 2'b00};
               w_mem_wdata_nxt = r_wdata;
            end else if (w_hit) begin
               w_state_nxt     = S_RESP;
               w_cpu_ready_nxt = 1'b1;
               w_cpu_rdata_nxt = r_data_arr[{w_idx, w_off}];
            end else begin
               w_state_nxt    = S_FILL;
               w_cnt_nxt      = '0;
               w_mem_req_nxt  = 1'b1;
               w_mem_we_nxt   = 1'b0;
               w_mem_addr_nxt = {w_tag, w_idx, OFF_W'(0), 2'b00};
            end
         end
         S_FILL: begin
            if (r_mem_req && bus.mem_ack) begin
               w_fill_wr     = 1'b1;
               w_mem_req_nxt = 1'b0;
               if (r_cnt == OFF_W'(LINE_WORDS - 1)) begin
                  w_fill_done     = 1'b1;
                  w_state_nxt     = S_RESP;
                  w_cpu_ready_nxt = 1'b1;
                  w_cpu_rdata_nxt = (w_off == r_cnt) ? bus.mem_rdata
                                                     : r_data_arr[{w_idx, w_off}];
               end else begin
                  w_cnt_nxt = r_cnt + OFF_W'(1);
               end
            end else if (!r_mem_req) begin
               // Re-issue for the next word after the one-cycle gap
               w_mem_req_nxt  = 1'b1;
               w_mem_addr_nxt = {w_tag, w_idx, r_cnt, 2'b00};
            end
         end
         S_WRITE: begin
            if (r_mem_req && bus.mem_ack) begin
               w_write_upd     = r_hit;
               w_mem_req_nxt   = 1'b0;
               w_mem_we_nxt    = 1'b0;
               w_state_nxt     = S_RESP;
               w_cpu_ready_nxt = 1'b1;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered outputs, request latch, fill counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cpu_ready <= 1'b0;
         r_cpu_rdata <= '0;
         r_busy      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_hit       <= 1'b0;
      end else begin
         r_cpu_ready <= w_cpu_ready_nxt;
         r_cpu_rdata <= w_cpu_rdata_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_cnt       <= w_cnt_nxt;
         if (w_latch) begin
            r_addr  <= bus.cpu_addr[31:2];
            r_wdata <= bus.cpu_wdata;
            r_we    <= bus.cpu_we;
         end
         if (r_state == S_LOOKUP) r_hit <= w_hit;
      end
   end

   // Valid bits: cleared by reset or flush, set only once a fill completes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             r_valid <= '0;
      else if (w_flush)     r_valid <= '0;
      else if (w_fill_done) r_valid[w_idx] <= 1'b1;
   end

   // Tag and data arrays (not reset; guarded by the valid bits)
   always_ff @(posedge clk) begin
      if (w_fill_wr)   r_data_arr[{w_idx, r_cnt}] <= bus.mem_rdata;
      if (w_write_upd) r_data_arr[{w_idx, w_off}] <= r_wdata;
      if (w_fill_done) r_tag_arr[w_idx] <= w_tag;
   end
endmodule

// File: tb/tb_limn2600_cache_ctrl.sv
// Directed bench for limn2600_cache_ctrl: table of CPU accesses against a
// one-cycle-ack memory responder, plus hand sequences for flush and reset.
module tb_limn2600_cache_ctrl;
   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   limn2600_cache_ctrl_if bus ();

   limn2600_cache_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: ack one cycle after a fresh request, log every transfer
   logic [31:0] mem_q [logic [31:0]];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic        log_we   [$];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_q.exists(a)) return mem_q[a];
      return 32'h0000_00A0 + ((a - 32'h0000_0100) >> 2);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mem_ack   <= 1'b0;
         bus.mem_rdata <= '0;
      end else if (bus.mem_req && !bus.mem_ack) begin
         bus.mem_ack <= 1'b1;
         log_addr.push_back(bus.mem_addr);
         log_data.push_back(bus.mem_wdata);
         log_we.push_back(bus.mem_we);
         if (bus.mem_we) mem_q[bus.mem_addr] = bus.mem_wdata;
         else            bus.mem_rdata <= mem_rd(bus.mem_addr);
      end else begin
         bus.mem_ack <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One CPU access; fmode 0 plain, 1 flush with the request, 2 flush pulse mid-access
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int fmode, output logic [31:0] rdata, output int cycles,
                         output logic busy_mid, output logic ok);
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      if (fmode == 1) bus.flush = 1'b1;
      cycles   = 0;
      ok       = 1'b0;
      busy_mid = 1'b0;
      rdata    = '0;
      while (cycles < 100 && !ok) begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 1 && fmode == 1) bus.flush = 1'b0;
         if (cycles == 5 && fmode == 2) bus.flush = 1'b1;
         if (cycles == 6 && fmode == 2) bus.flush = 1'b0;
         if (cycles == 2) busy_mid = bus.busy;
         if (bus.cpu_ready) begin
            ok    = 1'b1;
            rdata = bus.cpu_rdata;
         end
      end
      bus.cpu_req = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_one_cycle", 32'(bus.cpu_ready), 32'd0);
      chk("busy_back_idle", 32'(bus.busy), 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_cycles;
      int          exp_ops;
      logic [31:0] exp_maddr;
   } vec_t;

   vec_t vecs [15];

   task automatic run_vec(input string name, input vec_t v, input int fmode);
      logic [31:0] rd;
      int          cyc;
      logic        bm;
      logic        ok;
      int          base;
      base = log_addr.size();
      access(v.we, v.addr, v.wdata, fmode, rd, cyc, bm, ok);
      chk({name, "_done"}, 32'(ok), 32'd1);
      chk({name, "_rdata"}, rd, v.exp_rdata);
      chk({name, "_cycles"}, 32'(cyc), 32'(v.exp_cycles));
      chk({name, "_busy"}, 32'(bm), 32'd1);
      chk({name, "_memops"}, 32'(log_addr.size() - base), 32'(v.exp_ops));
      if (v.exp_ops > 0 && log_addr.size() > base) begin
         chk({name, "_maddr"}, log_addr[base], v.exp_maddr);
         chk({name, "_mwe"}, 32'(log_we[base]), 32'(v.we));
         if (v.we) chk({name, "_mwdata"}, log_data[base], v.wdata);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   base;
      int   guard;

      n_total = 0;
      n_bad   = 0;
      rst           = 1'b0;
      bus.flush     = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;

      //            we    addr          wdata         rdata         cyc ops maddr
      vecs[0]  = '{1'b0, 32'h0000_0108, 32'h0,        32'h0000_00A2, 2, 0, 32'h0};
      vecs[1]  = '{1'b1, 32'h0000_0104, 32'hDEADBEEF, 32'h0000_00A2, 4, 1, 32'h0000_0104};
      vecs[2]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hDEADBEEF,  2, 0, 32'h0};
      vecs[3]  = '{1'b1, 32'h0000_1000, 32'h12345678, 32'hDEADBEEF,  4, 1, 32'h0000_1000};
      vecs[4]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hDEADBEEF,  2, 0, 32'h0};
      vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,        32'h12345678, 13, 4, 32'h0000_1000};
      vecs[6]  = '{1'b0, 32'h0000_0500, 32'h0,        32'h0000_01A0, 13, 4, 32'h0000_0500};
      vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_00A0, 13, 4, 32'h0000_0100};
      vecs[8]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hDEADBEEF,  2, 0, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_02C4, 32'h0,        32'h0000_0111, 13, 4, 32'h0000_02C0};
      vecs[10] = '{1'b1, 32'h0000_02C6, 32'hCAFEF00D, 32'h0000_0111,  4, 1, 32'h0000_02C4};
      vecs[11] = '{1'b0, 32'h0000_02C4, 32'h0,        32'hCAFEF00D,  2, 0, 32'h0};
      vecs[12] = '{1'b0, 32'h0000_02C8, 32'h0,        32'h0000_0112,  2, 0, 32'h0};
      vecs[13] = '{1'b0, 32'h0000_030C, 32'h0,        32'h0000_0123, 13, 4, 32'h0000_0300};
      vecs[14] = '{1'b0, 32'h0000_0104, 32'h0,        32'hDEADBEEF, 13, 4, 32'h0000_0100};

      // Reset values
      #12;
      chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Cold read of 0x100: four word fills in address order
      base = log_addr.size();
      v = '{1'b0, 32'h0000_0100, 32'h0, 32'h0000_00A0, 13, 4, 32'h0000_0100};
      run_vec("cold_read", v, 0);
      for (int k = 0; k < 4; k++) begin
         if (log_addr.size() > base + k) begin
            chk("cold_fill_addr", log_addr[base+k], 32'h0000_0100 + 32'(4 * k));
            chk("cold_fill_we", 32'(log_we[base+k]), 32'd0);
         end
      end

      for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

      // Flush together with a request: flush first, request then misses
      v = '{1'b0, 32'h0000_02C8, 32'h0, 32'h0000_0112, 14, 4, 32'h0000_02C0};
      run_vec("flush_with_req", v, 1);
      v = '{1'b0, 32'h0000_02C4, 32'h0, 32'hCAFEF00D, 2, 0, 32'h0};
      run_vec("after_flush_hit", v, 0);

      // Flush pulsed during a fill is ignored; line ends up valid
      v = '{1'b0, 32'h0000_0700, 32'h0, 32'h0000_0220, 13, 4, 32'h0000_0700};
      run_vec("flush_mid_fill", v, 2);
      v = '{1'b0, 32'h0000_0704, 32'h0, 32'h0000_0221, 2, 0, 32'h0};
      run_vec("fill_kept_hit", v, 0);

      // Reset after the second fill word: request drops at once, line stays invalid
      base = log_addr.size();
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_0900;
      guard = 0;
      while (guard < 100 && !(log_addr.size() == base + 2 && bus.mem_req && !bus.mem_ack)) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("rst_mid_reached", 32'(guard < 100), 32'd1);
      chk("rst_mid_req_before", 32'(bus.mem_req), 32'd1);
      bus.cpu_req = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_rdata", bus.cpu_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      v = '{1'b0, 32'h0000_0900, 32'h0, 32'h0000_02A0, 13, 4, 32'h0000_0900};
      run_vec("after_abort_miss", v, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
